// File: rtl/mac_dot_sequencer.sv
// ----------------------------------------------------------------------------
// mac_dot_sequencer
//
// Job-framed dot-product engine around a 4x4 unsigned multiply-accumulate
// datapath. A job is launched with start/len from IDLE. Then exactly len
// operand pairs are taken over a valid/ready channel. Their products pass
// through a one-stage product register into a wrapping accumulator. The final
// sum is offered on a valid/ready result channel.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous, active-high reset
//   start      job request, sampled only in IDLE
//   len        number of operand pairs in the job (sampled with start)
//   abort      synchronous abort; highest priority in every state
//   busy       high whenever the sequencer is not IDLE
//   op_valid   operand pair valid
//   op_ready   sequencer accepts an operand pair (RUN only)
//   op_a       4-bit unsigned multiplicand
//   op_b       4-bit unsigned multiplier
//   res_valid  result valid (DONE only)
//   res_ready  consumer accepts the result
//   result     dot-product sum, modulo 2^ACC_W
//   overflow   sticky flag: the job sum exceeded 2^ACC_W-1
// ----------------------------------------------------------------------------
module mac_dot_sequencer #(
    parameter int LEN_W = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_a,
    input  logic [3:0]       op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [ACC_W-1:0] acc;
    logic             ovf_q;
    logic [LEN_W-1:0] cnt;
    logic [7:0]       prod_q;
    logic             prod_v;

    logic             launch;
    logic             beat;
    logic             last_beat;
    logic [ACC_W:0]   sum;

    // Abort outranks both a job launch and a beat handshake in the same cycle.
    assign launch    = (state == IDLE) && start && !abort;
    assign beat      = op_valid && op_ready && !abort;
    assign last_beat = beat && (cnt == LEN_W'(1));

    // One extra bit catches the carry out of the wrapping accumulator.
    assign sum = {1'b0, acc} + (ACC_W+1)'(prod_q);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so every path drives state_nx and no latch is inferred.
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nx = (len == '0) ? DONE : RUN;
                RUN:     if (last_beat) state_nx = DRAIN;
                // Stay until the last product has been folded into acc, so
                // result is final on the first DONE cycle.
                DRAIN:   if (!prod_v) state_nx = DONE;
                DONE:    if (res_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output logic (Moore: depends on state only)
    // ------------------------------------------------------------------------
    always_comb begin
        busy      = (state != IDLE);
        op_ready  = (state == RUN);
        res_valid = (state == DONE);
    end

    assign result   = acc;
    assign overflow = ovf_q;

    // ------------------------------------------------------------------------
    // Datapath: product register, beat counter, accumulator
    // ------------------------------------------------------------------------
    // The accept of beat k and the accumulate of beat k-1 happen on the same
    // edge. This sustains one beat per cycle without bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            ovf_q  <= 1'b0;
            cnt    <= '0;
            prod_q <= '0;
            prod_v <= 1'b0;
        end else if (abort && (state != IDLE)) begin
            acc    <= '0;
            ovf_q  <= 1'b0;
            cnt    <= '0;
            prod_v <= 1'b0;
        end else if (launch) begin
            acc    <= '0;
            ovf_q  <= 1'b0;
            cnt    <= len;
            prod_v <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples pre-edge values.
            prod_v <= beat;
            if (beat) begin
                prod_q <= {4'b0, op_a} * {4'b0, op_b};
                cnt    <= cnt - LEN_W'(1);
            end
            if (prod_v) begin
                acc   <= sum[ACC_W-1:0];
                ovf_q <= ovf_q | sum[ACC_W];
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mac_dot_sequencer
//
// Drives two instances side by side from the same stimulus: the default
// ACC_W=12 build and an ACC_W=8 build that exercises wrap and overflow.
// A job-level model in the bench tracks the following:
//   - how many beats remain,
//   - a two-edge tail after the last beat,
//   - the exact (unbounded) sum of products.
// From these it derives every visible output. The modular result and the
// overflow flag come straight from that exact sum.
// ----------------------------------------------------------------------------
module tb_mac_dot_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  len = '0;
    logic        abort = 1'b0;
    logic        op_valid = 1'b0;
    logic [3:0]  op_a = '0;
    logic [3:0]  op_b = '0;
    logic        res_ready = 1'b0;

    logic        busy, op_ready, res_valid, overflow;
    logic [11:0] result;
    logic        busy8, op_ready8, res_valid8, overflow8;
    logic [7:0]  result8;

    mac_dot_sequencer #(.LEN_W(4), .ACC_W(12)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .busy(busy), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .res_valid(res_valid),
        .res_ready(res_ready), .result(result), .overflow(overflow)
    );

    mac_dot_sequencer #(.LEN_W(4), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .busy(busy8), .op_valid(op_valid), .op_ready(op_ready8),
        .op_a(op_a), .op_b(op_b), .res_valid(res_valid8),
        .res_ready(res_ready), .result(result8), .overflow(overflow8)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    int     m_left = 0;   // beats still to be accepted
    int     m_tail = 0;   // edges left before the result is offered
    bit     m_done = 1'b0;
    longint m_sum  = 0;   // exact sum of accepted products

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0; m_tail <= 0; m_done <= 1'b0; m_sum <= 0;
        end else if (m_left == 0 && m_tail == 0 && !m_done) begin
            if (start && !abort) begin
                m_sum  <= 0;
                m_left <= int'(len);
                m_done <= (len == 4'd0);
            end
        end else if (abort) begin
            m_left <= 0; m_tail <= 0; m_done <= 1'b0; m_sum <= 0;
        end else if (m_left > 0) begin
            if (op_valid) begin
                m_sum  <= m_sum + longint'(int'(op_a) * int'(op_b));
                m_left <= m_left - 1;
                if (m_left == 1) m_tail <= 2;
            end
        end else if (m_tail > 0) begin
            m_tail <= m_tail - 1;
            if (m_tail == 1) m_done <= 1'b1;
        end else if (res_ready) begin
            m_done <= 1'b0;
        end
    end

    // Compare process: every falling edge, away from the active edge.
    always @(negedge clk) begin
        check("busy",       32'(busy),       32'(m_left > 0 || m_tail > 0 || m_done));
        check("busy8",      32'(busy8),      32'(m_left > 0 || m_tail > 0 || m_done));
        check("op_ready",   32'(op_ready),   32'(m_left > 0));
        check("op_ready8",  32'(op_ready8),  32'(m_left > 0));
        check("res_valid",  32'(res_valid),  32'(m_done));
        check("res_valid8", 32'(res_valid8), 32'(m_done));
        // The accumulator is only settled while idle or offering the result.
        if (m_left == 0 && m_tail == 0) begin
            check("result",    32'(result),    32'(m_sum % 64'd4096));
            check("overflow",  32'(overflow),  32'(m_sum >= 64'd4096));
            check("result8",   32'(result8),   32'(m_sum % 64'd256));
            check("overflow8", 32'(overflow8), 32'(m_sum >= 64'd256));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (all entered and left just after a falling edge)
    // ------------------------------------------------------------------------
    logic [3:0] pa [16];
    logic [3:0] pb [16];

    task automatic start_job(input int n);
        start = 1'b1;
        len   = 4'(n);
        @(negedge clk);
        start = 1'b0;
        len   = 4'($urandom);
    endtask

    task automatic send_beat(input logic [3:0] a, input logic [3:0] b);
        int t;
        t = 0;
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        while (!op_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("op_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
        op_a     = 4'($urandom);
        op_b     = 4'($urandom);
    endtask

    task automatic feed(input int n, input int gap_lo, input int gap_hi);
        for (int i = 0; i < n; i++) begin
            send_beat(pa[i], pb[i]);
            if (i < n - 1) repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
        end
    endtask

    task automatic wait_res();
        int t;
        t = 0;
        while (!res_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("res_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_res(input int hold);
        repeat (hold) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        int     c0;
        int     n;
        longint s;

        repeat (2) @(negedge clk);
        check("reset_busy",   32'(busy),      32'd0);
        check("reset_result", 32'(result),    32'd0);
        check("reset_resv",   32'(res_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-job after 2 of 4 beats, then a fresh job: 1*1 + 2*2 = 5.
        for (int i = 0; i < 4; i++) begin pa[i] = 4'd9; pb[i] = 4'd7; end
        start_job(4);
        feed(2, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy",     32'(busy),      32'd0);
        check("midrst_op_ready", 32'(op_ready),  32'd0);
        check("midrst_resv",     32'(res_valid), 32'd0);
        check("midrst_result",   32'(result),    32'd0);
        check("midrst_overflow", 32'(overflow),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        pa[0] = 4'd1; pb[0] = 4'd1; pa[1] = 4'd2; pb[1] = 4'd2;
        start_job(2);
        feed(2, 0, 0);
        wait_res();
        check("job5_result", 32'(result), 32'd5);
        finish_res(0);

        // Full throughput, 4 x (15,15), res_ready held high: 900 after 6 edges.
        for (int i = 0; i < 4; i++) begin pa[i] = 4'd15; pb[i] = 4'd15; end
        res_ready = 1'b1;
        start_job(4);
        c0 = cyc;
        feed(4, 0, 0);
        wait_res();
        check("job900_latency",  32'(cyc - c0), 32'd6);
        check("job900_result",   32'(result),   32'd900);
        check("job900_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        check("job900_one_cycle", 32'(res_valid), 32'd0);
        res_ready = 1'b0;

        // Gapped beats: 3*5 + 0*9 + 7*2 = 29.
        pa[0] = 4'd3; pb[0] = 4'd5; pa[1] = 4'd0; pb[1] = 4'd9; pa[2] = 4'd7; pb[2] = 4'd2;
        start_job(3);
        feed(3, 2, 2);
        wait_res();
        check("job29_result", 32'(result), 32'd29);
        finish_res(1);

        // Wrap: 2 x 225 = 450 -> 194 with overflow in 8 bits; then 2*3 = 6.
        pa[0] = 4'd15; pb[0] = 4'd15; pa[1] = 4'd15; pb[1] = 4'd15;
        start_job(2);
        feed(2, 0, 0);
        wait_res();
        check("wrap8_result",    32'(result8),   32'd194);
        check("wrap8_overflow",  32'(overflow8), 32'd1);
        check("wrap12_result",   32'(result),    32'd450);
        check("wrap12_overflow", 32'(overflow),  32'd0);
        finish_res(0);
        pa[0] = 4'd2; pb[0] = 4'd3;
        start_job(1);
        feed(1, 0, 0);
        wait_res();
        check("after_wrap_result",   32'(result8),   32'd6);
        check("after_wrap_overflow", 32'(overflow8), 32'd0);
        finish_res(0);

        // len=0: result offered right away; held for 5 cycles with start pulses.
        start_job(0);
        check("len0_resv",   32'(res_valid), 32'd1);
        check("len0_result", 32'(result),    32'd0);
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom_range(1, 0));
            len   = 4'($urandom);
            @(negedge clk);
            check("len0_hold_resv", 32'(res_valid), 32'd1);
        end
        start = 1'b0;
        finish_res(0);
        check("len0_released", 32'(busy), 32'd0);

        // Abort after 1 of 3 beats, with a beat offered on the abort edge.
        pa[0] = 4'd4; pb[0] = 4'd4;
        start_job(3);
        feed(1, 0, 0);
        abort = 1'b1; op_valid = 1'b1; op_a = 4'd3; op_b = 4'd3;
        @(negedge clk);
        abort = 1'b0; op_valid = 1'b0;
        check("abort_busy",   32'(busy),      32'd0);
        check("abort_resv",   32'(res_valid), 32'd0);
        check("abort_result", 32'(result),    32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_resv", 32'(res_valid), 32'd0);

        // Abort and start together in IDLE: the job is not launched.
        abort = 1'b1; start = 1'b1; len = 4'd2;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_start_idle", 32'(busy), 32'd0);
        @(negedge clk);

        // Randomized jobs.
        for (int j = 0; j < 25; j++) begin
            n = $urandom_range(15, 0);
            s = 0;
            for (int i = 0; i < 16; i++) begin
                pa[i] = 4'($urandom);
                pb[i] = 4'($urandom);
                if (i < n) s = s + longint'(int'(pa[i]) * int'(pb[i]));
            end
            start_job(n);
            feed(n, 0, 2);
            wait_res();
            check("rand_result",  32'(result),  32'(s % 64'd4096));
            check("rand_result8", 32'(result8), 32'(s % 64'd256));
            finish_res($urandom_range(3, 0));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
